// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: redirect, stall and fetch handshake bundle between the PC sequencer and its neighbours.
interface pc_sequencer_if #(parameter int K = 32);
   logic         jump_en;
   logic [K-1:0] jump_target;
   logic         stall;
   logic         fetch_ack;
   logic [K-1:0] pc_out;
   logic         fetch_req;
   logic         redirect_pend;
   logic         misalign_err;
   modport master (output jump_en, jump_target, stall, fetch_ack,
                   input  pc_out, fetch_req, redirect_pend, misalign_err);
   modport slave  (input  jump_en, jump_target, stall, fetch_ack,
                   output pc_out, fetch_req, redirect_pend, misalign_err);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and fetch handshake.
// Redirects arriving during an outstanding fetch are held until the ack.
module pc_sequencer #(
   parameter int K          = 32,
   parameter int RESET_PC   = 0,
   parameter int INC        = 4,
   parameter int ALIGN_BITS = 2
) (
   input logic             clk,
   input logic             rst_n,
   pc_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
   state_t       r_state;
   logic [K-1:0] r_pc, r_held;
   logic         r_req, r_pend, r_err;
   logic [K-1:0] w_mask, w_tgt;
   logic         w_mis;
   assign w_mask = {{(K-ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};
   assign w_tgt  = bus.jump_target & w_mask;
   assign w_mis  = |(bus.jump_target & ~w_mask);
   assign bus.pc_out        = r_pc;
   assign bus.fetch_req     = r_req;
   assign bus.redirect_pend = r_pend;
   assign bus.misalign_err  = r_err;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= BOOT;
         r_pc    <= K'(RESET_PC);
         r_held  <= '0;
         r_req   <= 1'b0;
         r_pend  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (bus.jump_en && w_mis) r_err <= 1'b1;
         case (r_state)
            FETCH: begin
               if (bus.fetch_ack) begin
                  r_pc    <= bus.jump_en ? w_tgt : r_pend ? r_held : r_pc + K'(INC);
                  r_pend  <= 1'b0;
                  r_state <= bus.stall ? HOLD : FETCH;
                  r_req   <= !bus.stall;
               end else if (bus.jump_en) begin
                  r_held <= w_tgt;
                  r_pend <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.jump_en) r_pc <= w_tgt;
               r_state <= bus.stall ? HOLD : FETCH;
               r_req   <= !bus.stall;
            end
            default: begin
               // no request is outstanding in BOOT, so a redirect lands immediately
               if (bus.jump_en) r_pc <= w_tgt;
               r_state <= FETCH;
               r_req   <= 1'b1;
            end
         endcase
      end
   end
endmodule
